fetch_align_buffer: RTL and testbench

//  Small direct-mapped line buffer between the fetch stage and the lower memory port (lowX).

---
 rtl/ceres_pkg.sv | 33 +++
 rtl/align_line_store.sv | 51 +++++
 rtl/fetch_align_buffer.sv | 184 ++++++++++++++++++
 tb/tb_fetch_align_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ceres_pkg.sv
// Shared fetch/lowX handshake types and the default address and block widths.
package ceres_pkg;
  localparam int XLEN     = 32;
  localparam int BLK_SIZE = 128;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic            uncached;
    logic [XLEN-1:0] addr;
  } abuff_req_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] blk;
  } abuff_res_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic            uncached;
    logic [XLEN-1:0] addr;
  } blowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] blk;
  } blowX_res_t;

  typedef enum logic [1:0] {IDLE, FILL, UC_LO, UC_HI} abuf_state_e;
endpackage

// File: rtl/align_line_store.sv
// Direct-mapped valid/tag/data arrays: two combinational read ports, one write port.
// Reads have zero latency; writes land on the rising edge.
module align_line_store #(
  parameter int NUM_SET  = 2,
  parameter int TAG_W    = 27,
  parameter int BLK_SIZE = 128,
  localparam int IDX     = $clog2(NUM_SET)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [IDX-1:0]      rd0_idx,
  output logic                rd0_vld,
  output logic [TAG_W-1:0]    rd0_tag,
  output logic [BLK_SIZE-1:0] rd0_dat,
  input  logic [IDX-1:0]      rd1_idx,
  output logic                rd1_vld,
  output logic [TAG_W-1:0]    rd1_tag,
  output logic [BLK_SIZE-1:0] rd1_dat,
  input  logic                wr_en,
  input  logic [IDX-1:0]      wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [BLK_SIZE-1:0] wr_dat
);
  logic [NUM_SET-1:0]  vld_q;
  logic [TAG_W-1:0]    tag_q [NUM_SET];
  logic [BLK_SIZE-1:0] dat_q [NUM_SET];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_q <= '0;
    end else if (wr_en) begin
      vld_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are qualified by the valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      dat_q[wr_idx] <= wr_dat;
    end
  end

  assign rd0_vld = vld_q[rd0_idx];
  assign rd0_tag = tag_q[rd0_idx];
  assign rd0_dat = dat_q[rd0_idx];
  assign rd1_vld = vld_q[rd1_idx];
  assign rd1_tag = tag_q[rd1_idx];
  assign rd1_dat = dat_q[rd1_idx];
endmodule

// File: rtl/fetch_align_buffer.sv
// Line buffer returning a 32-bit parcel from any halfword address, refilling from lowX.
// Hits are zero-latency; misses hold buffer_miss_o until the refill or bypass completes.
module fetch_align_buffer
  import ceres_pkg::*;
#(
  parameter int CACHE_SIZE = 256,
  parameter int NUM_WAY    = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  abuff_req_t buff_req_i,
  output abuff_res_t buff_res_o,
  output logic       buffer_miss_o,
  input  blowX_res_t lowX_res_i,
  output blowX_req_t lowX_req_o
);
  localparam int NUM_SET = CACHE_SIZE / BLK_SIZE / NUM_WAY;
  localparam int BOFFSET = $clog2(BLK_SIZE / 8);
  localparam int IDX     = $clog2(NUM_SET);
  localparam int TAG_W   = XLEN - BOFFSET - IDX;
  localparam int NHW     = BLK_SIZE / DATA_WIDTH;
  localparam int KW      = BOFFSET - 1;

  typedef logic [NHW-1:0][DATA_WIDTH-1:0] hw_blk_t;

  abuf_state_e           state_q, state_d;
  logic [XLEN-1:0]       lx_addr_q, lx_addr_d;
  logic [KW-1:0]         off_q, off_d;
  logic                  unal_q, unal_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  uc_vld_q, uc_vld_d;
  logic [XLEN-1:0]       uc_dat_q, uc_dat_d;

  logic [XLEN-1:0] lo_addr, hi_addr;
  logic [KW-1:0]   k;
  logic            unal, hit_lo, hit_hi, hit, wr_en;
  logic            rd0_vld, rd1_vld;
  logic [TAG_W-1:0] rd0_tag, rd1_tag;
  hw_blk_t         lo_hw, hi_hw, res_hw;
  logic            unused_bits;

  function automatic logic [XLEN-1:0] pick(input hw_blk_t b, input logic [KW-1:0] kk);
    logic [KW-1:0] kp1;
    kp1 = kk + 1'b1;
    return {b[kp1], b[kk]};
  endfunction

  assign lo_addr     = {buff_req_i.addr[XLEN-1:BOFFSET], {BOFFSET{1'b0}}};
  assign hi_addr     = lo_addr + XLEN'(BLK_SIZE / 8);
  assign k           = buff_req_i.addr[BOFFSET-1:1];
  assign unal        = &k;
  assign res_hw      = lowX_res_i.blk;
  assign unused_bits = ^{buff_req_i.ready, buff_req_i.addr[0], lowX_res_i.ready};

  align_line_store #(.NUM_SET(NUM_SET), .TAG_W(TAG_W), .BLK_SIZE(BLK_SIZE)) u_store (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .rd0_idx (lo_addr[BOFFSET+IDX-1:BOFFSET]),
    .rd0_vld (rd0_vld),
    .rd0_tag (rd0_tag),
    .rd0_dat (lo_hw),
    .rd1_idx (hi_addr[BOFFSET+IDX-1:BOFFSET]),
    .rd1_vld (rd1_vld),
    .rd1_tag (rd1_tag),
    .rd1_dat (hi_hw),
    .wr_en   (wr_en),
    .wr_idx  (lx_addr_q[BOFFSET+IDX-1:BOFFSET]),
    .wr_tag  (lx_addr_q[XLEN-1:BOFFSET+IDX]),
    .wr_dat  (lowX_res_i.blk)
  );

  assign hit_lo = rd0_vld && (rd0_tag == lo_addr[XLEN-1:BOFFSET+IDX]);
  assign hit_hi = rd1_vld && (rd1_tag == hi_addr[XLEN-1:BOFFSET+IDX]);
  assign hit    = hit_lo && (!unal || hit_hi);

  always_comb begin
    state_d       = state_q;
    lx_addr_d     = lx_addr_q;
    off_d         = off_q;
    unal_d        = unal_q;
    hold_d        = hold_q;
    uc_vld_d      = 1'b0;
    uc_dat_d      = uc_dat_q;
    buff_res_o    = '0;
    lowX_req_o    = '0;
    lowX_req_o.ready = 1'b1;
    buffer_miss_o = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      IDLE: begin
        buff_res_o.ready = 1'b1;
        if (uc_vld_q) begin
          buff_res_o.valid = 1'b1;
          buff_res_o.blk   = uc_dat_q;
        end else if (buff_req_i.valid && !flush_i) begin
          if (buff_req_i.uncached) begin
            buffer_miss_o       = 1'b1;
            lowX_req_o.valid    = 1'b1;
            lowX_req_o.uncached = 1'b1;
            lowX_req_o.addr     = lo_addr;
            lx_addr_d           = lo_addr;
            off_d               = k;
            unal_d              = unal;
            state_d             = UC_LO;
          end else if (hit) begin
            buff_res_o.valid = 1'b1;
            buff_res_o.blk   = unal ? {hi_hw[0], lo_hw[NHW-1]} : pick(lo_hw, k);
          end else begin
            // Low line is refilled first; the high line follows on a later pass.
            buffer_miss_o    = 1'b1;
            lowX_req_o.valid = 1'b1;
            lowX_req_o.addr  = hit_lo ? hi_addr : lo_addr;
            lx_addr_d        = lowX_req_o.addr;
            state_d          = FILL;
          end
        end
      end
      FILL: begin
        buffer_miss_o    = 1'b1;
        lowX_req_o.valid = 1'b1;
        lowX_req_o.addr  = lx_addr_q;
        if (lowX_res_i.valid) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end
      end
      UC_LO, UC_HI: begin
        buffer_miss_o       = 1'b1;
        lowX_req_o.valid    = 1'b1;
        lowX_req_o.uncached = 1'b1;
        lowX_req_o.addr     = lx_addr_q;
        if (lowX_res_i.valid) begin
          if (state_q == UC_HI) begin
            uc_dat_d = {res_hw[0], hold_q};
            uc_vld_d = 1'b1;
            state_d  = IDLE;
          end else if (unal_q) begin
            hold_d    = res_hw[NHW-1];
            lx_addr_d = lx_addr_q + XLEN'(BLK_SIZE / 8);
            state_d   = UC_HI;
          end else begin
            uc_dat_d = pick(res_hw, off_q);
            uc_vld_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      wr_en = 1'b0;
    end
    if (rst_i) begin
      buff_res_o       = '0;
      lowX_req_o       = '0;
      lowX_req_o.ready = 1'b1;
      buffer_miss_o    = 1'b0;
      wr_en            = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q   <= IDLE;
      lx_addr_q <= '0;
      off_q     <= '0;
      unal_q    <= 1'b0;
      hold_q    <= '0;
      uc_vld_q  <= 1'b0;
      uc_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      lx_addr_q <= lx_addr_d;
      off_q     <= off_d;
      unal_q    <= unal_d;
      hold_q    <= hold_d;
      uc_vld_q  <= uc_vld_d;
      uc_dat_q  <= uc_dat_d;
    end
  end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer with a one-cycle lowX responder and a parcel scoreboard.
module tb_fetch_align_buffer;
  import ceres_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i, flush_i;
  abuff_req_t buff_req_i;
  abuff_res_t buff_res_o;
  logic       buffer_miss_o;
  blowX_res_t lowX_res_i;
  blowX_req_t lowX_req_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  logic        lowx_en, late_pulse;
  blowX_req_t  exp_lx;

  fetch_align_buffer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .buff_req_i    (buff_req_i),
    .buff_res_o    (buff_res_o),
    .buffer_miss_o (buffer_miss_o),
    .lowX_res_i    (lowX_res_i),
    .lowX_req_o    (lowX_req_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] mem_blk(input logic [31:0] a);
    logic [127:0] b;
    case (a)
      32'h10:  b = 128'hAAAABBBB_CCCCDDDD_EEEEFFFF_11112222;
      32'h20:  b = {2{64'h12345678_9ABCDEF0}};
      32'hF0:  b = {4{32'hDEADBEEF}};
      default: for (int j = 0; j < 8; j++) b[16*j +: 16] = {a[11:0], 4'(j)};
    endcase
    return b;
  endfunction

  // Memory answers once, in the cycle after it sees a request.
  always @(posedge clk_i) begin : lowx_model
    logic        fire;
    logic [31:0] a;
    fire = (lowx_en && lowX_req_o.valid && !lowX_res_i.valid) || late_pulse;
    a    = lowX_req_o.addr;
    #1;
    lowX_res_i.valid = fire;
    lowX_res_i.ready = 1'b1;
    lowX_res_i.blk   = fire ? mem_blk(a) : '0;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic uc, input logic [31:0] exp,
                       input int lat, input logic [31:0] lx_addr);
    logic [31:0] e;
    bit          got;
    got = 1'b0;
    buff_req_i.valid    = 1'b1;
    buff_req_i.ready    = 1'b1;
    buff_req_i.uncached = uc;
    buff_req_i.addr     = a;
    sb.push_back(exp);
    #1;
    chk("miss_first_cycle", buffer_miss_o, lat != 0);
    if (lat != 0) begin
      chk("lowx_addr", lowX_req_o.addr, lx_addr);
      chk("lowx_uncached", lowX_req_o.uncached, uc);
    end
    for (int c = 0; c <= 20; c++) begin
      if (buff_res_o.valid) begin
        e = sb.pop_front();
        chk("parcel", buff_res_o.blk, e);
        chk("latency", c, lat);
        got = 1'b1;
        break;
      end
      @(negedge clk_i); #1;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL timeout addr=%0h observed=no_response expected=response", a);
    end
    buff_req_i.valid = 1'b0;
    @(negedge clk_i); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_res"}, buff_res_o, '0);
    chk({tag, "_lowx"}, lowX_req_o, exp_lx);
    chk({tag, "_miss"}, buffer_miss_o, 1'b0);
  endtask

  initial begin
    rst_i      = 1'b1;
    flush_i    = 1'b0;
    buff_req_i = '0;
    lowx_en    = 1'b1;
    late_pulse = 1'b0;
    exp_lx       = '0;
    exp_lx.ready = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    chk("idle_ready", buff_res_o.ready, 1'b1);

    // Aligned miss then hit
    fetch(32'h10, 1'b0, 32'h11112222, 2, 32'h10);
    fetch(32'h10, 1'b0, 32'h11112222, 0, 32'h0);
    // Mid-block, evicts set 1
    fetch(32'hF8, 1'b0, 32'hDEADBEEF, 2, 32'hF0);
    // Straddling parcel needs two refills
    fetch(32'h1E, 1'b0, 32'hDEF0AAAA, 4, 32'h10);
    fetch(32'h1E, 1'b0, 32'hDEF0AAAA, 0, 32'h0);
    // Uncached aligned and straddling, then no allocation
    fetch(32'h104, 1'b1, 32'h10031002, 2, 32'h100);
    fetch(32'h11E, 1'b1, 32'h12001107, 4, 32'h110);
    fetch(32'h104, 1'b0, 32'h10031002, 2, 32'h100);

    // Uncached with silent memory, then flush
    lowx_en = 1'b0;
    buff_req_i.valid    = 1'b1;
    buff_req_i.uncached = 1'b1;
    buff_req_i.addr     = 32'h100;
    repeat (4) begin @(negedge clk_i); #1; end
    chk("uc_hang_miss", buffer_miss_o, 1'b1);
    chk("uc_hang_valid", lowX_req_o.valid, 1'b1);
    chk("uc_hang_uncached", lowX_req_o.uncached, 1'b1);
    chk("uc_hang_addr", lowX_req_o.addr, 32'h100);
    chk("uc_hang_no_res", buff_res_o.valid, 1'b0);
    flush_i = 1'b1;
    buff_req_i.valid = 1'b0;
    @(negedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_lowx_drop", lowX_req_o.valid, 1'b0);
    chk("flush_miss_drop", buffer_miss_o, 1'b0);
    lowx_en = 1'b1;

    // Flush invalidates lines
    fetch(32'h10, 1'b0, 32'h11112222, 2, 32'h10);
    fetch(32'h10, 1'b0, 32'h11112222, 0, 32'h0);
    flush_i = 1'b1;
    @(negedge clk_i); #1;
    flush_i = 1'b0;
    fetch(32'h10, 1'b0, 32'h11112222, 2, 32'h10);

    // Reset during FILL, then a late response
    lowx_en = 1'b0;
    buff_req_i.valid    = 1'b1;
    buff_req_i.uncached = 1'b0;
    buff_req_i.addr     = 32'h30;
    @(negedge clk_i); #1;
    chk("fill_miss", buffer_miss_o, 1'b1);
    chk("fill_addr", lowX_req_o.addr, 32'h30);
    rst_i = 1'b1;
    buff_req_i.valid = 1'b0;
    @(negedge clk_i); #1;
    chk_reset_outputs("reset_mid_fill");
    rst_i      = 1'b0;
    late_pulse = 1'b1;
    @(negedge clk_i); #1;
    late_pulse = 1'b0;
    @(negedge clk_i); #1;
    chk("late_res_lowx", lowX_req_o.valid, 1'b0);
    chk("late_res_miss", buffer_miss_o, 1'b0);
    lowx_en = 1'b1;
    fetch(32'h30, 1'b0, 32'h03010300, 2, 32'h30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
